// File: rtl/ibex_xif_hpm_ctrl.sv
// ibex_xif_hpm_ctrl: controller for a bank of hardware performance counters.
// Maps core event pulses onto per-counter increment strobes through a
// per-counter event-select mask and an inhibit bit. Sequences CSR accesses
// into the counter lo/hi write ports with a three-cycle handshake
// (IDLE -> ACCESS -> RESP). Tracks sticky counter overflow.
// Optional feature macro: HPM_OVERFLOW_IRQ_EN adds a registered irq_o output
// raised when any non-inhibited counter has a pending overflow.
module ibex_xif_hpm_ctrl #(
  parameter int NumCounters  = 4,
  parameter int NumEvents    = 16,
  parameter int CounterWidth = 40
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumEvents-1:0]      event_i,
  input  logic                      csr_req_i,
  input  logic                      csr_we_i,
  input  logic [1:0]                csr_sel_i,
  input  logic [4:0]                csr_idx_i,
  input  logic [31:0]               csr_wdata_i,
  output logic                      csr_gnt_o,
  output logic                      csr_rvalid_o,
  output logic [31:0]               csr_rdata_o,
  output logic                      csr_err_o,
  input  logic [64*NumCounters-1:0] cnt_val_i,
  output logic [NumCounters-1:0]    cnt_inc_o,
  output logic [NumCounters-1:0]    cnt_we_o,
  output logic [NumCounters-1:0]    cnt_weh_o,
  output logic [31:0]               cnt_wdata_o,
  output logic [NumCounters-1:0]    ovf_pending_o,
  input  logic [NumCounters-1:0]    ovf_clr_i
`ifdef HPM_OVERFLOW_IRQ_EN
  ,
  output logic                      irq_o
`endif
);

  localparam logic [1:0] SelEvsel   = 2'd0;
  localparam logic [1:0] SelInhibit = 2'd1;
  localparam logic [1:0] SelCntLo   = 2'd2;
  localparam logic [1:0] SelCntHi   = 2'd3;

  localparam logic [5:0] NumCnt6 = 6'(NumCounters);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                                state_q;
  logic                                  gnt_q;
  logic                                  rvalid_q;
  logic [31:0]                           rdata_q;
  logic                                  err_q;

  logic [NumCounters-1:0][NumEvents-1:0] evsel_q;
  logic [NumCounters-1:0]                inhibit_q;
  logic [NumEvents-1:0]                  event_q;
  logic [NumCounters-1:0]                ovf_q;
  logic [NumCounters-1:0]                ovf_set;

  logic                                  idx_ok;
  logic                                  acc_en;
  logic                                  wr_en;
  logic [NumEvents-1:0]                  rd_evsel;
  logic [31:0]                           rd_lo;
  logic [31:0]                           rd_hi;
  logic [31:0]                           rdata_d;

  // INHIBIT is a single register and ignores the index; the others need a valid counter.
  assign idx_ok = (csr_sel_i == SelInhibit) || ({1'b0, csr_idx_i} < NumCnt6);
  assign acc_en = (state_q == ACCESS);
  assign wr_en  = acc_en && csr_we_i && idx_ok;

  // Select the addressed counter's evsel mask and value halves for the read path.
  always_comb begin
    rd_evsel = '0;
    rd_lo    = '0;
    rd_hi    = '0;
    for (int i = 0; i < NumCounters; i++) begin
      if (csr_idx_i == 5'(i)) begin
        rd_evsel = evsel_q[i];
        rd_lo    = cnt_val_i[64*i +: 32];
        rd_hi    = cnt_val_i[64*i+32 +: 32];
      end
    end
  end

  // Read data as sampled in ACCESS; writes and bad indices return zero.
  always_comb begin
    rdata_d = '0;
    if (!csr_we_i && idx_ok) begin
      case (csr_sel_i)
        SelEvsel:   rdata_d[NumEvents-1:0]   = rd_evsel;
        SelInhibit: rdata_d[NumCounters-1:0] = inhibit_q;
        SelCntLo:   rdata_d                  = rd_lo;
        SelCntHi:   rdata_d                  = rd_hi;
        default:    rdata_d                  = '0;
      endcase
    end
  end

  // Access sequencer: grant in ACCESS, one-cycle response in RESP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rvalid_q <= 1'b0;
          rdata_q  <= '0;
          err_q    <= 1'b0;
          if (csr_req_i) begin
            state_q <= ACCESS;
            gnt_q   <= 1'b1;
          end
        end
        ACCESS: begin
          state_q  <= RESP;
          gnt_q    <= 1'b0;
          rvalid_q <= 1'b1;
          rdata_q  <= rdata_d;
          err_q    <= !idx_ok;
        end
        RESP: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
          rdata_q  <= '0;
          err_q    <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          gnt_q    <= 1'b0;
          rvalid_q <= 1'b0;
          rdata_q  <= '0;
          err_q    <= 1'b0;
        end
      endcase
    end
  end

  assign csr_gnt_o    = gnt_q;
  assign csr_rvalid_o = rvalid_q;
  assign csr_rdata_o  = rdata_q;
  assign csr_err_o    = err_q;

  // Counter write strobes follow the live request during ACCESS.
  always_comb begin
    cnt_we_o    = '0;
    cnt_weh_o   = '0;
    cnt_wdata_o = '0;
    if (wr_en && (csr_sel_i == SelCntLo || csr_sel_i == SelCntHi)) begin
      cnt_wdata_o = csr_wdata_i;
      for (int i = 0; i < NumCounters; i++) begin
        if (csr_idx_i == 5'(i)) begin
          cnt_we_o[i]  = (csr_sel_i == SelCntLo);
          cnt_weh_o[i] = (csr_sel_i == SelCntHi);
        end
      end
    end
  end

  // Configuration registers update at the end of the ACCESS cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      evsel_q   <= '0;
      inhibit_q <= '0;
    end else if (wr_en) begin
      if (csr_sel_i == SelInhibit) begin
        inhibit_q <= csr_wdata_i[NumCounters-1:0];
      end else if (csr_sel_i == SelEvsel) begin
        for (int i = 0; i < NumCounters; i++) begin
          if (csr_idx_i == 5'(i)) begin
            evsel_q[i] <= csr_wdata_i[NumEvents-1:0];
          end
        end
      end
    end
  end

  // Event stage: one cycle of latency between core pulses and increments.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      event_q <= '0;
    end else begin
      event_q <= event_i;
    end
  end

  // Increment when any selected event fired, unless inhibited or being written.
  always_comb begin
    cnt_inc_o = '0;
    ovf_set   = '0;
    for (int i = 0; i < NumCounters; i++) begin
      cnt_inc_o[i] = (|(event_q & evsel_q[i])) & ~inhibit_q[i] & ~(cnt_we_o[i] | cnt_weh_o[i]);
      ovf_set[i]   = cnt_inc_o[i] & (&cnt_val_i[64*i +: CounterWidth]);
    end
  end

  // Sticky overflow flags; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~ovf_clr_i) | ovf_set;
    end
  end

  assign ovf_pending_o = ovf_q;

`ifdef HPM_OVERFLOW_IRQ_EN
  logic irq_q;

  // Interrupt follows pending overflows of counters that are not inhibited.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(ovf_q & ~inhibit_q);
    end
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_ibex_xif_hpm_ctrl.sv
// Directed testbench for ibex_xif_hpm_ctrl (default parameters).
module tb_ibex_xif_hpm_ctrl;
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [15:0]  event_i;
  logic         csr_req_i;
  logic         csr_we_i;
  logic [1:0]   csr_sel_i;
  logic [4:0]   csr_idx_i;
  logic [31:0]  csr_wdata_i;
  logic         csr_gnt_o;
  logic         csr_rvalid_o;
  logic [31:0]  csr_rdata_o;
  logic         csr_err_o;
  logic [255:0] cnt_val_i;
  logic [3:0]   cnt_inc_o;
  logic [3:0]   cnt_we_o;
  logic [3:0]   cnt_weh_o;
  logic [31:0]  cnt_wdata_o;
  logic [3:0]   ovf_pending_o;
  logic [3:0]   ovf_clr_i;
`ifdef HPM_OVERFLOW_IRQ_EN
  logic         irq_o;
`endif

  int checks = 0;
  int errors = 0;
  logic done = 1'b0;

  logic [3:0]  a_we, a_weh, a_inc;
  logic [31:0] a_wdata, r;
  logic        e;

  ibex_xif_hpm_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .event_i(event_i),
    .csr_req_i(csr_req_i), .csr_we_i(csr_we_i), .csr_sel_i(csr_sel_i),
    .csr_idx_i(csr_idx_i), .csr_wdata_i(csr_wdata_i),
    .csr_gnt_o(csr_gnt_o), .csr_rvalid_o(csr_rvalid_o),
    .csr_rdata_o(csr_rdata_o), .csr_err_o(csr_err_o),
    .cnt_val_i(cnt_val_i), .cnt_inc_o(cnt_inc_o), .cnt_we_o(cnt_we_o),
    .cnt_weh_o(cnt_weh_o), .cnt_wdata_o(cnt_wdata_o),
    .ovf_pending_o(ovf_pending_o), .ovf_clr_i(ovf_clr_i)
`ifdef HPM_OVERFLOW_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full CSR transaction; returns what was seen in ACCESS and RESP.
  task automatic access(input logic we, input logic [1:0] sel, input logic [4:0] idx,
                        input logic [31:0] wdata,
                        output logic [3:0] o_we, output logic [3:0] o_weh,
                        output logic [31:0] o_wdata, output logic [3:0] o_inc,
                        output logic [31:0] o_rdata, output logic o_err);
    csr_req_i = 1'b1; csr_we_i = we; csr_sel_i = sel; csr_idx_i = idx; csr_wdata_i = wdata;
    tick();
    chk("gnt_access", csr_gnt_o, 1'b1);
    chk("rvalid_access", csr_rvalid_o, 1'b0);
    o_we = cnt_we_o; o_weh = cnt_weh_o; o_wdata = cnt_wdata_o; o_inc = cnt_inc_o;
    tick();
    chk("gnt_resp", csr_gnt_o, 1'b0);
    chk("rvalid_resp", csr_rvalid_o, 1'b1);
    o_rdata = csr_rdata_o; o_err = csr_err_o;
    csr_req_i = 1'b0;
    tick();
    chk("rvalid_idle", csr_rvalid_o, 1'b0);
  endtask

  initial begin
    #100000;
    if (!done) begin
      $error("FAIL timeout waiting for test completion");
      $finish;
    end
  end

  initial begin
    rst_i = 1'b1; event_i = '0; csr_req_i = 1'b0; csr_we_i = 1'b0; csr_sel_i = '0;
    csr_idx_i = '0; csr_wdata_i = '0; cnt_val_i = '0; ovf_clr_i = '0;
    tick();
    tick();
    chk("rst_gnt", csr_gnt_o, 1'b0);
    chk("rst_rvalid", csr_rvalid_o, 1'b0);
    chk("rst_rdata", csr_rdata_o, 32'h0);
    chk("rst_inc", cnt_inc_o, 4'h0);
    chk("rst_we", cnt_we_o, 4'h0);
    chk("rst_ovf", ovf_pending_o, 4'h0);
    rst_i = 1'b0;
    tick();

    // 1: evsel[0]=1, five event cycles -> five increments, one-cycle delay
    access(1'b1, 2'd0, 5'd0, 32'h1, a_we, a_weh, a_wdata, a_inc, r, e);
    chk("evsel_wr_rdata", r, 32'h0);
    event_i = 16'h0001;
    chk("ev_latency", cnt_inc_o, 4'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("ev_inc", cnt_inc_o, 4'b0001);
    end
    event_i = '0;
    tick();
    chk("ev_stop", cnt_inc_o, 4'h0);
    chk("ev_no_ovf", ovf_pending_o, 4'h0);

    // 2: read CNT_HI of counter 1
    cnt_val_i[127:64] = 64'h0000_00AB_0000_0000;
    access(1'b0, 2'd3, 5'd1, 32'h0, a_we, a_weh, a_wdata, a_inc, r, e);
    chk("hi_rdata", r, 32'h0000_00AB);
    chk("hi_err", e, 1'b0);
    chk("hi_no_we", a_we | a_weh, 4'h0);

    // 3: write counter 0 low half while its events fire
    event_i = 16'h0001;
    tick();
    chk("pre_wr_inc", cnt_inc_o, 4'b0001);
    access(1'b1, 2'd2, 5'd0, 32'h1234, a_we, a_weh, a_wdata, a_inc, r, e);
    chk("lo_we", a_we, 4'b0001);
    chk("lo_weh", a_weh, 4'b0000);
    chk("lo_wdata", a_wdata, 32'h1234);
    chk("lo_inc_dropped", a_inc, 4'b0000);
    chk("lo_rdata", r, 32'h0);
    chk("post_wr_inc", cnt_inc_o, 4'b0001);
    access(1'b1, 2'd3, 5'd3, 32'hCAFE, a_we, a_weh, a_wdata, a_inc, r, e);
    chk("hi3_weh", a_weh, 4'b1000);
    chk("hi3_we", a_we, 4'b0000);
    chk("hi3_inc_kept", a_inc, 4'b0001);

    // 4: inhibit counter 0, then bad-index accesses
    access(1'b1, 2'd1, 5'd0, 32'h1, a_we, a_weh, a_wdata, a_inc, r, e);
    chk("inh_access_inc", a_inc, 4'b0001);
    chk("inh_inc", cnt_inc_o, 4'b0000);
    access(1'b0, 2'd1, 5'd9, 32'h0, a_we, a_weh, a_wdata, a_inc, r, e);
    chk("inh_rdata", r, 32'h1);
    chk("inh_err", e, 1'b0);
    access(1'b0, 2'd0, 5'd7, 32'h0, a_we, a_weh, a_wdata, a_inc, r, e);
    chk("bad_rd_err", e, 1'b1);
    chk("bad_rd_rdata", r, 32'h0);
    access(1'b1, 2'd2, 5'd7, 32'h55, a_we, a_weh, a_wdata, a_inc, r, e);
    chk("bad_wr_err", e, 1'b1);
    chk("bad_wr_we", a_we, 4'h0);
    event_i = '0;

    // 5: overflow on counter 2
    access(1'b1, 2'd0, 5'd2, 32'h2, a_we, a_weh, a_wdata, a_inc, r, e);
    cnt_val_i[191:128] = 64'h0000_00FF_FFFF_FFFF;
    event_i = 16'h0002;
    tick();
    chk("ovf_inc", cnt_inc_o, 4'b0100);
    chk("ovf_not_yet", ovf_pending_o, 4'h0);
    event_i = '0;
    tick();
    chk("ovf_set", ovf_pending_o, 4'b0100);
`ifdef HPM_OVERFLOW_IRQ_EN
    chk("irq_not_yet", irq_o, 1'b0);
`endif
    tick();
`ifdef HPM_OVERFLOW_IRQ_EN
    chk("irq_set", irq_o, 1'b1);
`endif
    event_i = 16'h0002;
    tick();
    ovf_clr_i = 4'b0100;
    event_i = '0;
    tick();
    chk("ovf_set_wins", ovf_pending_o, 4'b0100);
    tick();
    chk("ovf_cleared", ovf_pending_o, 4'b0000);
    ovf_clr_i = '0;
    tick();
`ifdef HPM_OVERFLOW_IRQ_EN
    chk("irq_cleared", irq_o, 1'b0);
`endif

    // 6: reset in the middle of an access
    csr_req_i = 1'b1; csr_we_i = 1'b1; csr_sel_i = 2'd2; csr_idx_i = 5'd1; csr_wdata_i = 32'h5;
    tick();
    chk("mid_gnt", csr_gnt_o, 1'b1);
    chk("mid_we", cnt_we_o, 4'b0010);
    rst_i = 1'b1;
    #1;
    chk("abort_gnt", csr_gnt_o, 1'b0);
    chk("abort_we", cnt_we_o, 4'h0);
    chk("abort_wdata", cnt_wdata_o, 32'h0);
    csr_req_i = 1'b0;
    tick();
    chk("abort_rvalid", csr_rvalid_o, 1'b0);
    rst_i = 1'b0;
    event_i = 16'h0003;
    tick();
    chk("abort_evsel_clr", cnt_inc_o, 4'h0);
    event_i = '0;
    access(1'b0, 2'd1, 5'd0, 32'h0, a_we, a_weh, a_wdata, a_inc, r, e);
    chk("after_rst_inh", r, 32'h0);
    chk("after_rst_err", e, 1'b0);

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
